systolic_skew_feeder: RTL



---
 rtl/systolic_skew_feeder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Re-times full rows of matrix a into the diagonal order a systolic array consumes, then zero-flushes it.
// Optional build macro SKEW_ZERO_FILL_EN: blanks every lane position that carries no real data.
module systolic_skew_feeder #(
  parameter int BitSize     = 8,
  parameter int NumOfInputs = 2,
  parameter int NumOfNerves = 2,
  parameter int NumOfRows   = 4
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic                           stall,
  input  logic                           in_valid,
  input  logic                           in_start,
  input  logic [NumOfInputs*BitSize-1:0] in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic                           out_start,
  output logic [NumOfInputs*BitSize-1:0] out_data,
  output logic                           out_last
);

  localparam int FlushLen  = NumOfInputs - 1 + NumOfNerves;
  localparam int FlushCntW = (FlushLen < 2) ? 1 : $clog2(FlushLen);
  localparam int RowCntW   = $clog2(NumOfRows + 1);

  localparam logic [FlushCntW-1:0] FlushLast = FlushCntW'(FlushLen - 1);
  localparam logic [RowCntW-1:0]   RowsLast  = RowCntW'(NumOfRows - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [RowCntW-1:0]   row_cnt_q, row_cnt_d;
  logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
  logic                 out_valid_q, out_start_q, out_last_q;
  logic                 advance, load, last_beat, flushing;

  assign in_ready = !stall && (state_q != FLUSH);
  assign flushing = (state_q == FLUSH);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    flush_cnt_d = flush_cnt_q;
    advance     = 1'b0;
    load        = 1'b0;
    last_beat   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready && in_start) begin
          load        = 1'b1;
          advance     = 1'b1;
          row_cnt_d   = RowCntW'(1);
          flush_cnt_d = '0;
          state_d     = (NumOfRows == 1) ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (in_valid && in_ready) begin
          advance   = 1'b1;
          row_cnt_d = row_cnt_q + RowCntW'(1);
          if (row_cnt_q == RowsLast) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          advance     = 1'b1;
          flush_cnt_d = flush_cnt_q + FlushCntW'(1);
          if (flush_cnt_q == FlushLast) begin
            last_beat = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= advance;
      out_start_q <= load;
      out_last_q  <= last_beat;
    end
  end

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_last  = out_last_q;

  // Lane k is a (k+1)-deep shift chain; its last stage drives lane k of out_data.
  for (genvar k = 0; k < NumOfInputs; k++) begin : g_lane
    logic [BitSize-1:0] data_q [k+1];
    logic [BitSize-1:0] lane_d;

    assign lane_d = flushing ? '0 : in_data[(NumOfInputs-1-k)*BitSize +: BitSize];

    // NOTE: the chains are register arrays that must read zero straight out of reset, so they are reset.
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        for (int i = 0; i <= k; i++) data_q[i] <= '0;
      end else if (advance) begin
        data_q[0] <= lane_d;
        for (int i = 1; i <= k; i++) data_q[i] <= data_q[i-1];
      end
    end

`ifdef SKEW_ZERO_FILL_EN
    logic [k:0] tag_q, tag_d;

    always_comb begin
      tag_d    = tag_q << 1;
      tag_d[0] = !flushing;
    end

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)       tag_q <= '0;
      else if (advance) tag_q <= tag_d;
    end

    assign out_data[(NumOfInputs-1-k)*BitSize +: BitSize] = tag_q[k] ? data_q[k] : '0;
`else
    assign out_data[(NumOfInputs-1-k)*BitSize +: BitSize] = data_q[k];
`endif
  end

  // A zero-length flush (one input, no columns) cannot produce an out_last beat.
  always @(posedge clk) begin
    if (res_n) assert (FlushLen > 0);
  end

endmodule
